// File: rtl/adsr_envelope_generator_if.sv
// ---------------------------------------------------------------------------
// adsr_envelope_generator_if
//   Control, parameter and sample bus of one ADSR envelope channel.
//
//   Controller -> envelope (inputs of the envelope block):
//     enable_i           channel enable; low forces IDLE
//     start_i            one-cycle pulse; starts or retriggers the envelope
//     sample_tick_i      one-cycle pulse; one audio sample step
//     attack_step_i      unsigned increment per tick in ATTACK
//     decay_step_i       unsigned decrement per tick in DECAY
//     release_step_i     unsigned decrement per tick in RELEASE
//     sustain_duration_i number of ticks spent in SUSTAIN
//     attack_level_i     attack peak, unsigned Q0.32
//     sustain_level_i    sustain plateau, unsigned Q0.32
//     wave_i             signed Q1.15 input sample
//   Envelope -> controller (outputs of the envelope block):
//     wave_o             signed Q1.15 enveloped sample
//     envelope_o         current envelope level, unsigned Q0.32
//     idle_o             high while the envelope is IDLE
//
//   master : drives the controls and sample (testbench / voice controller)
//   slave  : the envelope generator itself
// ---------------------------------------------------------------------------
interface adsr_envelope_generator_if;
    logic        enable_i;
    logic        start_i;
    logic        sample_tick_i;
    logic [31:0] attack_step_i;
    logic [31:0] decay_step_i;
    logic [31:0] release_step_i;
    logic [31:0] sustain_duration_i;
    logic [31:0] attack_level_i;
    logic [31:0] sustain_level_i;
    logic [15:0] wave_i;
    logic [15:0] wave_o;
    logic [31:0] envelope_o;
    logic        idle_o;

    modport master (
        output enable_i, start_i, sample_tick_i,
        output attack_step_i, decay_step_i, release_step_i, sustain_duration_i,
        output attack_level_i, sustain_level_i, wave_i,
        input  wave_o, envelope_o, idle_o
    );

    modport slave (
        input  enable_i, start_i, sample_tick_i,
        input  attack_step_i, decay_step_i, release_step_i, sustain_duration_i,
        input  attack_level_i, sustain_level_i, wave_i,
        output wave_o, envelope_o, idle_o
    );
endinterface

// File: rtl/adsr_envelope_generator.sv
// ---------------------------------------------------------------------------
// adsr_envelope_generator
//   Single-channel ADSR envelope. The envelope level (unsigned Q0.32) moves
//   once per sample tick through ATTACK, DECAY, SUSTAIN and RELEASE, and the
//   input sample is scaled by the upper 16 bits of the level on every tick.
//
//   Ports:
//     clk_i    clock, all state updates on the rising edge
//     rst_n_i  asynchronous active-low reset
//     bus      adsr_envelope_generator_if.slave (controls, parameters,
//              wave_i in; wave_o, envelope_o, idle_o out)
// ---------------------------------------------------------------------------
module adsr_envelope_generator (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    adsr_envelope_generator_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_env;
    logic [31:0]        w_env_nxt;
    logic [31:0]        r_cnt;
    logic [31:0]        w_cnt_nxt;
    logic [15:0]        r_wave;
    logic [15:0]        w_wave_nxt;
    logic               r_idle;
    logic               w_idle_nxt;

    // 33-bit arithmetic: bit 32 flags attack overflow / decay underflow,
    // and keeps cnt + 1 from wrapping when compared with the duration.
    logic [32:0]        w_attack_sum;
    logic [32:0]        w_decay_diff;
    logic [32:0]        w_cnt_inc;

    // Signed Q1.15 sample times the non-negative 17-bit gain {0, env[31:16]}.
    // Its magnitude stays below 2^31, so a 32-bit signed product is exact.
    logic signed [31:0] w_wave_ext;
    logic signed [31:0] w_gain;
    logic signed [31:0] w_product;

    assign w_attack_sum = {1'b0, r_env} + {1'b0, bus.attack_step_i};
    assign w_decay_diff = {1'b0, r_env} - {1'b0, bus.decay_step_i};
    assign w_cnt_inc    = {1'b0, r_cnt} + 33'd1;

    assign w_wave_ext   = {{16{bus.wave_i[15]}}, bus.wave_i};
    assign w_gain       = {16'd0, r_env[31:16]};
    assign w_product    = w_wave_ext * w_gain;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and envelope datapath
    // Priority: enable low, then start, then sample tick.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_cnt_nxt   = r_cnt;

        if (!bus.enable_i) begin
            w_state_nxt = ST_IDLE;
            w_env_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (bus.start_i) begin
            // Retrigger keeps the current level so the output does not click.
            w_state_nxt = ST_ATTACK;
            w_cnt_nxt   = '0;
        end else if (bus.sample_tick_i) begin
            case (r_state)
                ST_ATTACK: begin
                    if (w_attack_sum[32] || (w_attack_sum[31:0] >= bus.attack_level_i)) begin
                        w_env_nxt   = bus.attack_level_i;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_env_nxt   = w_attack_sum[31:0];
                    end
                end
                ST_DECAY: begin
                    if ((r_env <= bus.sustain_level_i) || w_decay_diff[32] ||
                        (w_decay_diff[31:0] <= bus.sustain_level_i)) begin
                        w_env_nxt   = bus.sustain_level_i;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_env_nxt   = w_decay_diff[31:0];
                    end
                end
                ST_SUSTAIN: begin
                    if (w_cnt_inc >= {1'b0, bus.sustain_duration_i}) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc[31:0];
                    end
                end
                ST_RELEASE: begin
                    if (r_env <= bus.release_step_i) begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_env_nxt   = r_env - bus.release_step_i;
                    end
                end
                default: begin
                    w_env_nxt   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: scaled sample uses the level from before this cycle's
    // update; the product is truncated to its Q1.15 bits [31:16].
    // -----------------------------------------------------------------------
    always_comb begin
        w_wave_nxt = r_wave;
        if (bus.sample_tick_i) begin
            if (!bus.enable_i || (r_state == ST_IDLE)) begin
                w_wave_nxt = '0;
            end else begin
                w_wave_nxt = 16'(w_product >>> 16);
            end
        end
        w_idle_nxt = (w_state_nxt == ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_env  <= '0;
            r_cnt  <= '0;
            r_wave <= '0;
            r_idle <= 1'b1;
        end else begin
            r_env  <= w_env_nxt;
            r_cnt  <= w_cnt_nxt;
            r_wave <= w_wave_nxt;
            r_idle <= w_idle_nxt;
        end
    end

    assign bus.wave_o     = r_wave;
    assign bus.envelope_o = r_env;
    assign bus.idle_o     = r_idle;

endmodule

// File: doc/adsr_envelope_generator.md
ADSR_ENVELOPE_GENERATOR -- requirements
Module: adsr_envelope_generator

Interface
REQ-001 SHALL have the following ports; one clock; reset is asynchronous and active-low:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- enable_i  input  1  channel enable; low forces IDLE
- start_i  input  1  single-cycle pulse; starts or retriggers the envelope
- sample_tick_i  input  1  single-cycle pulse; envelope and output advance once per audio sample
- attack_step_i  input  32  unsigned increment per tick in ATTACK
- decay_step_i  input  32  unsigned decrement per tick in DECAY
- release_step_i  input  32  unsigned decrement per tick in RELEASE
- sustain_duration_i  input  32  number of ticks spent in SUSTAIN
- attack_level_i  input  32  attack peak, unsigned Q0.32
- sustain_level_i  input  32  sustain plateau, unsigned Q0.32
- wave_i  input  16  signed Q1.15 input sample
- wave_o  output  16  signed Q1.15 enveloped sample
- envelope_o  output  32  current envelope level, unsigned Q0.32
- idle_o  output  1  high when the state is IDLE

Function
REQ-002 SHALL implement the states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE, held in a register env (32 b) with a sustain counter cnt (32 b).
REQ-003 Priority per cycle SHALL be: enable_i low, then start_i, then sample_tick_i.
REQ-004 enable_i low SHALL, on the next edge, set state=IDLE, env=0 and cnt=0, regardless of the other inputs.
REQ-005 start_i with enable_i high SHALL, on the next edge, set state=ATTACK and cnt=0 from any state, without waiting for a tick.
- env SHALL keep its current value, so a retrigger does not click.
- A tick in the same cycle SHALL be ignored.
REQ-006 Outside IDLE, and with start_i low, state and env SHALL change only on cycles with sample_tick_i high.
REQ-007 ATTACK, per tick: sum = env + attack_step_i, computed at 33 b.
- If sum ≥ attack_level_i, or sum overflows 32 b: env = attack_level_i and state = DECAY.
- Otherwise: env = sum.
REQ-008 DECAY, per tick:
- If env ≤ sustain_level_i, or env − decay_step_i ≤ sustain_level_i, or the subtraction underflows: env = sustain_level_i, cnt = 0, state = SUSTAIN.
- Otherwise: env = env − decay_step_i.
REQ-009 SUSTAIN, per tick: env held.
- If cnt + 1 ≥ sustain_duration_i: state = RELEASE.
- Otherwise: cnt increments.
- Result: SUSTAIN lasts max(1, sustain_duration_i) ticks.
REQ-010 RELEASE, per tick:
- If env ≤ release_step_i: env = 0 and state = IDLE.
- Otherwise: env = env − release_step_i.
REQ-011 In IDLE, env SHALL be 0 and ticks SHALL have no effect on state.
REQ-012 A zero attack, decay or release step SHALL hold the envelope in that state indefinitely, until start_i or enable_i low; this is not an error.
REQ-013 On each sample_tick_i, wave_o SHALL register (wave_i × {0, env[31:16]})[31:16].
- The product is signed 16 × signed 17 = 33 b and is truncated, not rounded.
- The env used is the value before this cycle's update.
- Latency is 1 cycle from tick to wave_o; wave_o holds between ticks.
REQ-014 wave_o SHALL register 0 on a tick when enable_i is low or state is IDLE.
REQ-015 envelope_o SHALL equal env, and idle_o SHALL equal (state == IDLE), both driven directly from registers.
REQ-016 All step and level inputs SHALL be sampled at the cycle in which they are used; changes mid-envelope take effect on the next tick.

Reset
REQ-017 While rst_n_i is low, asynchronously: state=IDLE, env=0, cnt=0, wave_o=0, envelope_o=0, idle_o=1.
REQ-018 Reset asserted mid-envelope SHALL abort immediately; after release of reset the block SHALL wait in IDLE for start_i.

Verification
REQ-019 Full cycle, ticks every 4 cycles:
- Stimulus: attack_step=0x4000_0000, attack_level=0xF000_0000, decay_step=0x1000_0000, sustain_level=0x8000_0000, sustain_duration=3, release_step=0x2000_0000, start pulse.
- Required env per tick: 0x4000_0000, 0x8000_0000, 0xC000_0000, 0xF000_0000 (DECAY), 0xE000_0000 … 0x8000_0000 (SUSTAIN), held for 3 ticks, then 0x6000_0000, 0x4000_0000, 0x2000_0000, 0 (IDLE, idle_o=1).
REQ-020 Output scaling:
- Stimulus: env=0x8000_0000, wave_i=0x7FFF, then wave_i=0x8000.
- Required: wave_o=0x3FFF, then wave_o=0xC000, each one cycle after the tick.
REQ-021 Retrigger:
- Stimulus: start pulse during RELEASE at env=0x4000_0000.
- Required: state=ATTACK next edge, env still 0x4000_0000; the next tick gives 0x8000_0000.
REQ-022 Priority:
- Stimulus: enable_i low together with start_i and a tick, in ATTACK.
- Required: next edge state=IDLE, env=0; on the next tick wave_o=0.
REQ-023 Boundaries:
- Stimulus: attack_step=0xFFFF_FFFF with attack_level=0xFFFF_FFFF; separately, sustain_duration=0.
- Required: ATTACK saturates to 0xFFFF_FFFF in 1 tick with no wrap; SUSTAIN lasts exactly 1 tick.
REQ-024 Reset mid-operation:
- Stimulus: rst_n_i low in SUSTAIN, not aligned to a clock edge.
- Required: all outputs reach reset values without a clock edge; the block stays IDLE after release until start_i.
